tape_save_decoder: RTL and testbench
====================================

// Module: tape_save_decoder
// PURPOSE
//  Capture side of the tape path: decodes the ZX81 SAVE pulse train on the machine's tape output (mic)
//  into bytes and buffers them for the control module, which writes them to SD as a .P image.
//  Counterpart of the .P playback module; sits beside it in the top level, fed by the zx01 mic output
//  and the 500 kHz tick.
// PARAMETERS
//  FIFO_DEPTH   16     byte FIFO entries, power of 2, 4..64
//  PULSE_MIN    40     min high time in ce ticks (80 us) for a pulse to count; shorter = glitch
//  GAP_MIN      400    low time in ce ticks (800 us) that closes a bit
//  BIT_THRESH   6      pulse count <= BIT_THRESH -> bit 0, else bit 1 (nominal 4 / 9)
//  EOF_TICKS    50000  low time in ce ticks (100 ms) that ends a recording
// PORTS
//  clk          in   1   system clock
//  n_reset      in   1   async reset, active low
//  ce_500k      in   1   one-clk-wide 500 kHz tick; all timing counts advance only on it
//  arm          in   1   record armed (OSD "record"); low = idle
//  mic_in       in   1   zx01 tape output, asynchronous, high = pulse
//  dout         out  8   FIFO head byte
//  dout_valid   out  1   FIFO not empty
//  dout_ready   in   1   consumer pop; byte transferred when valid & ready
//  rec_active   out  1   first pulse seen, EOF not yet reached
//  done         out  1   sticky: EOF detected; cleared when arm falls
//  overflow     out  1   sticky: byte dropped on full FIFO; cleared when arm falls
//  byte_count   out  16  bytes decoded since arm rose, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM IDLE, counters 0.
//  - mic_in passes a 2-flop sync on clk. Edges are detected on ce_500k ticks only.
//  - FSM:
//    - IDLE: when arm=1, go to WAIT.
//    - WAIT: on the first qualified pulse, go to BIT and set rec_active.
//    - BIT: count qualified pulses; the count saturates at 15.
//      - Low time reaches GAP_MIN with count>0: shift out one bit, MSB first. Bit = (count > BIT_THRESH).
//        Clear the count and go to GAP.
//    - GAP: a rising edge returns to BIT. Low time reaches EOF_TICKS: go to DONE.
//    - DONE: rec_active=0, done=1. Stay until arm=0.
//  - Any state with arm=0: go to IDLE.
//    - Partial byte and pulse count are discarded.
//    - done, overflow and byte_count are cleared.
//    - FIFO contents are kept so the consumer can drain them.
//  - Qualified pulse: high time >= PULSE_MIN ticks, counted at its falling edge.
//    - Shorter highs are ignored and do not reset the low-time counter.
//  - Low-time counter: 16 bits, saturating. Cleared on every qualified falling edge.
//  - After the 8th bit, the byte is pushed one clk later and byte_count increments (saturating).
//  - FIFO: first-word-fall-through; dout is valid in the same cycle dout_valid=1.
//    - Push on full with simultaneous pop: accepted.
//    - Push on full without pop: byte dropped, overflow=1, byte_count still increments.
//  - EOF with a partial byte pending: the partial bits are discarded. The ZX81 always saves whole bytes.
// CONFIGURATION
//  TAPE_SAVE_GLITCH_FILTER_EN defined:
//    - A 3-sample majority filter, updated on ce_500k, is inserted after the sync.
//    - Adds 2 ce ticks of latency to both edges; single-tick spikes are rejected.
//  Not defined: sync only. Behaviour is otherwise identical.
// TESTING
//  1. Reset with arm=1 and mic toggling -> all outputs 0 until n_reset rises. FSM then leaves IDLE.
//  2. Byte 0xA5: 8 bits, each 4 or 9 pulses of 150 us high / 150 us low, 1300 us gaps.
//     -> dout=0xA5, byte_count=1, rec_active=1.
//  3. Bytes 0x00, 0xFF, 0x3C, then 120 ms silence
//     -> FIFO pops in order 00, FF, 3C; done=1, rec_active=0.
//  4. 20 bytes with dout_ready=0 (FIFO_DEPTH=16) -> 16 stored, overflow=1, byte_count=20.
//     Then drain -> first 16 bytes intact.
//  5. 40 us spikes between pulses -> decoded value unchanged.
//     With TAPE_SAVE_GLITCH_FILTER_EN, a 2 us spike is also ignored.
//  6. arm dropped after 5 bits -> IDLE, no push; byte_count=0. Re-arm and send 0x81 -> dout=0x81.

Source files
------------

// File: rtl/tape_save_decoder.sv
// ZX81 SAVE pulse-train decoder: mic pulses -> bits -> bytes, buffered in a FWFT byte FIFO.
// Optional TAPE_SAVE_GLITCH_FILTER_EN adds a 3-sample majority filter after the mic synchroniser.
module tape_save_decoder #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PULSE_MIN  = 40,
    parameter int unsigned GAP_MIN    = 400,
    parameter int unsigned BIT_THRESH = 6,
    parameter int unsigned EOF_TICKS  = 50000
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        ce_500k,
    input  logic        arm,
    input  logic        mic_in,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        rec_active,
    output logic        done,
    output logic        overflow,
    output logic [15:0] byte_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BIT, S_GAP, S_DONE} state_t;

    state_t state;

    logic mic_meta, mic_sync, mic_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mic_meta <= 1'b0;
            mic_sync <= 1'b0;
        end else begin
            mic_meta <= mic_in;
            mic_sync <= mic_meta;
        end
    end

`ifdef TAPE_SAVE_GLITCH_FILTER_EN
    logic [1:0] hist;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hist  <= '0;
            mic_q <= 1'b0;
        end else if (ce_500k) begin
            hist  <= {hist[0], mic_sync};
            mic_q <= (hist[1] & hist[0]) | (hist[1] & mic_sync) | (hist[0] & mic_sync);
        end
    end
`else
    assign mic_q = mic_sync;
`endif

    logic        mic_prev;
    logic [15:0] high_cnt, low_cnt;
    logic        rise, qual_fall, gap_hit, eof_hit;

    assign rise      = ce_500k && !mic_prev && mic_q;
    assign qual_fall = ce_500k && mic_prev && !mic_q && (high_cnt >= 16'(PULSE_MIN));
    assign gap_hit   = low_cnt >= 16'(GAP_MIN);
    assign eof_hit   = low_cnt >= 16'(EOF_TICKS);

    // Low time only advances while the line is low; unqualified highs pause it without clearing.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mic_prev <= 1'b0;
            high_cnt <= '0;
            low_cnt  <= '0;
        end else if (ce_500k) begin
            mic_prev <= mic_q;
            if (mic_q) begin
                if (!mic_prev)
                    high_cnt <= 16'd1;
                else if (high_cnt != '1)
                    high_cnt <= high_cnt + 16'd1;
            end
            if (qual_fall)
                low_cnt <= '0;
            else if (!mic_q && low_cnt != '1)
                low_cnt <= low_cnt + 16'd1;
        end
    end

    logic [3:0] pulse_cnt;
    logic [2:0] bit_idx;
    logic [6:0] shreg;
    logic       bit_val;
    logic       push_req;
    logic [7:0] push_data;

    assign bit_val = pulse_cnt > 4'(BIT_THRESH);

    // A stray edge in GAP lands in BIT with no pulses counted; EOF is honoured there too.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= S_IDLE;
            pulse_cnt  <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            push_req   <= 1'b0;
            push_data  <= '0;
            rec_active <= 1'b0;
            done       <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (!arm) begin
                state      <= S_IDLE;
                pulse_cnt  <= '0;
                bit_idx    <= '0;
                rec_active <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: state <= S_WAIT;
                    S_WAIT: begin
                        if (qual_fall) begin
                            state      <= S_BIT;
                            pulse_cnt  <= 4'd1;
                            bit_idx    <= '0;
                            rec_active <= 1'b1;
                        end
                    end
                    S_BIT: begin
                        if (qual_fall) begin
                            if (pulse_cnt != 4'hF)
                                pulse_cnt <= pulse_cnt + 4'd1;
                        end else if (gap_hit && pulse_cnt != '0) begin
                            shreg     <= {shreg[5:0], bit_val};
                            pulse_cnt <= '0;
                            state     <= S_GAP;
                            if (bit_idx == 3'd7) begin
                                push_req  <= 1'b1;
                                push_data <= {shreg, bit_val};
                            end
                            bit_idx <= bit_idx + 3'd1;
                        end else if (pulse_cnt == '0 && eof_hit) begin
                            state      <= S_DONE;
                            rec_active <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (eof_hit) begin
                            state      <= S_DONE;
                            rec_active <= 1'b0;
                            done       <= 1'b1;
                        end else if (rise) begin
                            state <= S_BIT;
                        end
                    end
                    S_DONE: begin
                        rec_active <= 1'b0;
                        done       <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fill;
    logic          full, pop, push_ok;

    assign full       = fill == (AW+1)'(FIFO_DEPTH);
    assign dout_valid = fill != '0;
    assign pop        = dout_valid && dout_ready;
    assign push_ok    = push_req && (!full || pop);
    assign dout       = dout_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            overflow   <= 1'b0;
            byte_count <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (!arm) begin
                overflow   <= 1'b0;
                byte_count <= '0;
            end else if (push_req) begin
                if (full && !pop)
                    overflow <= 1'b1;
                if (byte_count != '1)
                    byte_count <= byte_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tape_save_decoder.sv
// Self-checking bench for tape_save_decoder with time-scaled pulse parameters.
module tb_tape_save_decoder;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned PMIN   = 3;
    localparam int unsigned GMIN   = 25;
    localparam int unsigned THRESH = 6;
    localparam int unsigned EOFT   = 400;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        ce_500k = 1'b0;
    logic        arm = 1'b1;
    logic        mic_in = 1'b0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        rec_active;
    logic        done;
    logic        overflow;
    logic [15:0] byte_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  model_q[$];
    int unsigned model_count = 0;
    bit          model_ovf = 1'b0;

    typedef struct {
        logic [7:0][4:0] pulses;
        logic [7:0]      exp;
    } vec_t;

    vec_t vecs[6];

    tape_save_decoder #(
        .FIFO_DEPTH(DEPTH),
        .PULSE_MIN (PMIN),
        .GAP_MIN   (GMIN),
        .BIT_THRESH(THRESH),
        .EOF_TICKS (EOFT)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .ce_500k   (ce_500k),
        .arm       (arm),
        .mic_in    (mic_in),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .rec_active(rec_active),
        .done      (done),
        .overflow  (overflow),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            ce_500k = ~ce_500k;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int unsigned n);
        repeat (2 * n) @(negedge clk);
    endtask

    // n pulses of hi ticks high / 4 low, then 40 more low ticks, optional spike at spike_at
    task automatic send_bit(input int unsigned n, input int unsigned hi,
                            input int unsigned spike_at, input int unsigned spike_w);
        for (int unsigned p = 0; p < n; p++) begin
            mic_in = 1'b1;
            ticks(hi);
            mic_in = 1'b0;
            ticks(4);
        end
        if (spike_at != 0) begin
            ticks(spike_at);
            mic_in = 1'b1;
            ticks(spike_w);
            mic_in = 1'b0;
            ticks(40 - spike_at);
        end else begin
            ticks(40);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int unsigned spike_at);
        for (int i = 7; i >= 0; i--)
            send_bit(v[i] ? 9 : 4, 4, spike_at, 2);
    endtask

    task automatic model_push(input logic [7:0] v);
        if (model_count != 65535)
            model_count++;
        if (model_q.size() < DEPTH)
            model_q.push_back(v);
        else
            model_ovf = 1'b1;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        check({name, "_valid"}, 32'(dout_valid), 32'd1);
        check({name, "_data"}, 32'(dout), 32'(exp));
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    task automatic pop_model(input string name);
        logic [7:0] e;
        if (model_q.size() == 0) begin
            check({name, "_model_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = model_q.pop_front();
            pop_expect(name, e);
        end
    endtask

    initial begin
        logic [7:0]  rv, eb;
        int unsigned n, hi, sp;

        vecs[0] = '{pulses: {5'd9, 5'd4, 5'd9, 5'd4, 5'd4, 5'd9, 5'd4, 5'd9}, exp: 8'hA5};
        vecs[1] = '{pulses: {5'd6, 5'd7, 5'd1, 5'd15, 5'd20, 5'd6, 5'd7, 5'd2}, exp: 8'h5A};
        vecs[2] = '{pulses: {8{5'd4}}, exp: 8'h00};
        vecs[3] = '{pulses: {8{5'd9}}, exp: 8'hFF};
        vecs[4] = '{pulses: {5'd4, 5'd4, 5'd9, 5'd9, 5'd9, 5'd9, 5'd4, 5'd4}, exp: 8'h3C};
        vecs[5] = '{pulses: {5'd9, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd9}, exp: 8'h81};

        // reset with arm high and mic toggling
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            mic_in = ~mic_in;
        end
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_rec", 32'(rec_active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", 32'(byte_count), 32'd0);
        mic_in = 1'b0;
        ticks(10);
        n_reset = 1'b1;
        ticks(10);

        // table-driven bytes including threshold and saturation boundaries
        for (int unsigned i = 0; i < 6; i++) begin
            for (int b = 7; b >= 0; b--)
                send_bit(int'(vecs[i].pulses[b]), 4, 0, 0);
            check("vec_rec", 32'(rec_active), 32'd1);
            check("vec_count", 32'(byte_count), i + 1);
            pop_expect("vec", vecs[i].exp);
            check("vec_empty", 32'(dout_valid), 32'd0);
        end

        // EOF after silence
        ticks(300);
        check("pre_eof_done", 32'(done), 32'd0);
        check("pre_eof_rec", 32'(rec_active), 32'd1);
        for (int t = 0; t < 700 && !done; t++)
            ticks(1);
        check("eof_done", 32'(done), 32'd1);
        check("eof_rec", 32'(rec_active), 32'd0);
        arm = 1'b0;
        ticks(2);
        check("disarm_done", 32'(done), 32'd0);
        check("disarm_count", 32'(byte_count), 32'd0);

        // overflow: 20 bytes into a 16-entry FIFO with no consumer
        model_count = 0;
        model_ovf = 1'b0;
        arm = 1'b1;
        ticks(4);
        for (int i = 0; i < 20; i++) begin
            rv = 8'($urandom);
            send_byte(rv, 0);
            model_push(rv);
            if (i == 15) begin
                check("full_ovf", 32'(overflow), 32'(model_ovf));
                check("full_count", 32'(byte_count), model_count);
            end
        end
        check("ovf_flag", 32'(overflow), 32'(model_ovf));
        check("ovf_count", 32'(byte_count), model_count);
        for (int i = 0; i < 16; i++)
            pop_model("drain");
        check("drain_empty", 32'(dout_valid), 32'd0);
        arm = 1'b0;
        ticks(2);
        check("ovf_clear", 32'(overflow), 32'd0);

        // spikes inside and after the bit gap
        model_count = 0;
        model_ovf = 1'b0;
        arm = 1'b1;
        ticks(4);
        send_byte(8'h5A, 8);
        model_push(8'h5A);
        pop_model("spike_in");
        send_byte(8'hC3, 30);
        model_push(8'hC3);
        pop_model("spike_after");
        check("spike_count", 32'(byte_count), model_count);

        // arm dropped mid-byte, then re-armed
        for (int b = 7; b > 2; b--)
            send_bit(4, 4, 0, 0);
        arm = 1'b0;
        ticks(50);
        check("abort_count", 32'(byte_count), 32'd0);
        check("abort_valid", 32'(dout_valid), 32'd0);
        check("abort_rec", 32'(rec_active), 32'd0);
        arm = 1'b1;
        ticks(4);
        send_byte(8'h81, 0);
        check("rearm_count", 32'(byte_count), 32'd1);
        pop_expect("rearm", 8'h81);
        model_count = 1;

        // randomized pulse counts, widths and spikes against the bit rule
        for (int i = 0; i < 4; i++) begin
            eb = '0;
            for (int b = 7; b >= 0; b--) begin
                n  = $urandom_range(1, 15);
                hi = $urandom_range(3, 6);
                case ($urandom_range(0, 2))
                    0:       sp = 0;
                    1:       sp = 8;
                    default: sp = 30;
                endcase
                send_bit(n, hi, sp, $urandom_range(1, 2));
                eb[b] = n > THRESH;
            end
            model_push(eb);
            check("rand_count", 32'(byte_count), model_count);
            pop_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
